// File: rtl/rhythm_judge_multi_if.sv
`default_nettype none
// ============================================================================
// Module : rhythm_judge_multi_if
// Control inputs and judge/display outputs of the multi-lane rhythm judge.
// Rev    : 1.0
// ============================================================================
interface rhythm_judge_multi_if #(
  parameter int LANES   = 4,
  parameter int MAP_LEN = 192,
  parameter int VIEW    = 10,
  parameter int SCORE_W = 8,
  parameter int COMBO_W = 8,
  parameter int LANE_W  = 2
);
  logic                     start;
  logic                     tick;
  logic [LANES*MAP_LEN-1:0] map_in;
  logic [LANES-1:0]         button;
  logic [LANES*VIEW-1:0]    lane_view;
  logic [SCORE_W-1:0]       score;
  logic [COMBO_W-1:0]       combo;
  logic [COMBO_W-1:0]       max_combo;
  logic [1:0]               accuracy;
  logic [LANE_W-1:0]        acc_lane;
  logic                     playing;
  logic                     done;

  modport master (
    output start, tick, map_in, button,
    input  lane_view, score, combo, max_combo, accuracy, acc_lane, playing, done
  );

  modport slave (
    input  start, tick, map_in, button,
    output lane_view, score, combo, max_combo, accuracy, acc_lane, playing, done
  );
endinterface
`default_nettype wire

// File: rtl/rhythm_judge_multi.sv
`default_nettype none
// ============================================================================
// Module : rhythm_judge_multi
// Per-lane note shifters advanced on a beat strobe, with press judging,
// saturating score/combo tracking and a worst-event accuracy report.
// Rev    : 1.0
// ============================================================================
module rhythm_judge_multi #(
  parameter int LANES       = 4,
  parameter int MAP_LEN     = 192,
  parameter int VIEW        = 10,
  parameter int SCORE_W     = 8,
  parameter int COMBO_W     = 8,
  parameter int LANE_W      = 2,
  parameter int PERFECT_PTS = 2,
  parameter int GOOD_PTS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  rhythm_judge_multi_if.slave  bus
);

  localparam int CNT_W = (MAP_LEN > 1) ? $clog2(MAP_LEN) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] ACC_NONE    = 2'b00;
  localparam logic [1:0] ACC_PERFECT = 2'b01;
  localparam logic [1:0] ACC_GOOD    = 2'b10;
  localparam logic [1:0] ACC_MISS    = 2'b11;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [COMBO_W-1:0] COMBO_MAX = '1;
  localparam logic [CNT_W-1:0]   LAST_TICK = CNT_W'(MAP_LEN - 1);

  logic [1:0]                    state_q,     state_d;
  logic [LANES-1:0][MAP_LEN-1:0] shifter_q,   shifter_d;
  logic [CNT_W-1:0]              tick_cnt_q,  tick_cnt_d;
  logic [LANES-1:0]              btn_q,       btn_d;
  logic [SCORE_W-1:0]            score_q,     score_d;
  logic [COMBO_W-1:0]            combo_q,     combo_d;
  logic [COMBO_W-1:0]            max_combo_q, max_combo_d;
  logic [1:0]                    accuracy_q,  accuracy_d;
  logic [LANE_W-1:0]             acc_lane_q,  acc_lane_d;

  logic [LANES-1:0]              press;
  logic [LANES-1:0][MAP_LEN-1:0] judged;
  logic [MAP_LEN-1:0]            lane_v;
  logic [1:0]                    lane_ev;
  logic                          lane_valid;
  logic [31:0]                   pts_sum;
  logic [31:0]                   hit_cnt;
  logic                          any_miss;
  logic                          any_event;
  logic [1:0]                    worst_ev;
  logic [LANE_W-1:0]             worst_lane;
  logic [32:0]                   score_sum;
  logic [32:0]                   combo_sum;
  logic [SCORE_W-1:0]            score_new;
  logic [COMBO_W-1:0]            combo_new;

  assign press = btn_q & ~bus.button;

  // Judge every lane against its pre-shift window, then shift what is left so
  // a note cleared by a same-cycle press can never also count as a miss.
  always_comb begin
    judged     = shifter_q;
    lane_v     = '0;
    lane_ev    = ACC_NONE;
    lane_valid = 1'b0;
    pts_sum    = '0;
    hit_cnt    = '0;
    any_miss   = 1'b0;
    any_event  = 1'b0;
    worst_ev   = ACC_NONE;
    worst_lane = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_v     = shifter_q[l];
      lane_ev    = ACC_NONE;
      lane_valid = 1'b0;
      if (press[l]) begin
        lane_valid = 1'b1;
        if (lane_v[1]) begin
          lane_v[1] = 1'b0;
          lane_ev   = ACC_PERFECT;
          pts_sum   = pts_sum + 32'(PERFECT_PTS);
          hit_cnt   = hit_cnt + 32'd1;
        end else if (lane_v[0]) begin
          lane_v[0] = 1'b0;
          lane_ev   = ACC_GOOD;
          pts_sum   = pts_sum + 32'(GOOD_PTS);
          hit_cnt   = hit_cnt + 32'd1;
        end else if (lane_v[2]) begin
          lane_v[2] = 1'b0;
          lane_ev   = ACC_GOOD;
          pts_sum   = pts_sum + 32'(GOOD_PTS);
          hit_cnt   = hit_cnt + 32'd1;
        end
      end
      if (bus.tick && lane_v[0]) begin
        lane_valid = 1'b1;
        lane_ev    = ACC_MISS;
        any_miss   = 1'b1;
      end
      if (bus.tick) begin
        lane_v = lane_v >> 1;
      end
      judged[l] = lane_v;
      // Strictly-worse test keeps the lowest lane among equal events.
      if (lane_valid && (!any_event || (lane_ev > worst_ev))) begin
        worst_ev   = lane_ev;
        worst_lane = LANE_W'(l);
      end
      any_event = any_event | lane_valid;
    end
  end

  always_comb begin
    score_sum = 33'(score_q) + 33'(pts_sum);
    combo_sum = 33'(combo_q) + 33'(hit_cnt);
    score_new = (score_sum > 33'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    if (any_miss) begin
      combo_new = '0;
    end else begin
      combo_new = (combo_sum > 33'(COMBO_MAX)) ? COMBO_MAX : combo_sum[COMBO_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    shifter_d   = shifter_q;
    tick_cnt_d  = tick_cnt_q;
    btn_d       = bus.button;
    score_d     = score_q;
    combo_d     = combo_q;
    max_combo_d = max_combo_q;
    accuracy_d  = accuracy_q;
    acc_lane_d  = acc_lane_q;
    case (state_q)
      ST_PLAY: begin
        if (bus.start) begin
          state_d   = ST_IDLE;
          shifter_d = '0;
        end else begin
          shifter_d = judged;
          score_d   = score_new;
          combo_d   = combo_new;
          if (combo_new > max_combo_q) begin
            max_combo_d = combo_new;
          end
          if (any_event) begin
            accuracy_d = worst_ev;
            acc_lane_d = worst_lane;
          end
          if (bus.tick) begin
            if (tick_cnt_q == LAST_TICK) begin
              state_d = ST_DONE;
            end else begin
              tick_cnt_d = tick_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: begin
        if (bus.start) begin
          state_d     = ST_PLAY;
          shifter_d   = bus.map_in;
          tick_cnt_d  = '0;
          score_d     = '0;
          combo_d     = '0;
          max_combo_d = '0;
          accuracy_d  = ACC_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shifter_q   <= '0;
      tick_cnt_q  <= '0;
      btn_q       <= '1;
      score_q     <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
      accuracy_q  <= ACC_NONE;
      acc_lane_q  <= '0;
    end else begin
      state_q     <= state_d;
      shifter_q   <= shifter_d;
      tick_cnt_q  <= tick_cnt_d;
      btn_q       <= btn_d;
      score_q     <= score_d;
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
      accuracy_q  <= accuracy_d;
      acc_lane_q  <= acc_lane_d;
    end
  end

  // Slot 0 is the hit line itself, so the display starts one slot ahead.
  for (genvar g = 0; g < LANES; g++) begin : g_view
    assign bus.lane_view[g*VIEW +: VIEW] = shifter_q[g][VIEW:1];
  end

  assign bus.score     = score_q;
  assign bus.combo     = combo_q;
  assign bus.max_combo = max_combo_q;
  assign bus.accuracy  = accuracy_q;
  assign bus.acc_lane  = acc_lane_q;
  assign bus.playing   = (state_q == ST_PLAY);
  assign bus.done      = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: doc/rhythm_judge_multi.md
Name: rhythm_judge_multi

Overview:
- Parametrised multi-lane successor to the single-lane note shifter/judge in the rhythm game datapath.
- Holds one note shift register per lane, loaded from a static map. Notes advance on an external beat strobe.
- Judges falling-edge button presses against a three-slot hit window and keeps score, combo and max combo with saturation.
- Sits between the 8 Hz tick generator and the HEX/VGA/LED display logic; runs entirely in the 50 MHz domain.

Parameters:
- LANES, 4, number of independent note lanes/buttons
- MAP_LEN, 192, notes per lane; also the tick count of one song
- VIEW, 10, look-ahead bits per lane exported for display
- SCORE_W, 8, score width
- COMBO_W, 8, combo and max_combo width
- LANE_W, 2, width of acc_lane; must satisfy 2**LANE_W >= LANES
- PERFECT_PTS, 2, points per perfect hit
- GOOD_PTS, 1, points per good hit

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  synchronous active-low reset
- start  in  1  single-cycle active-high pulse: start / abort / restart
- tick  in  1  single-cycle beat strobe; advances all lanes by one slot
- map_in  in  LANES*MAP_LEN  note map; lane l occupies bits [l*MAP_LEN +: MAP_LEN], bit 0 = earliest note
- button  in  LANES  active-low lane buttons, already synchronised
- lane_view  out  LANES*VIEW  lane l shows shifter[l][VIEW:1]
- score  out  SCORE_W  accumulated points
- combo  out  COMBO_W  current consecutive-hit count
- max_combo  out  COMBO_W  highest combo reached this song
- accuracy  out  2  last judgment: 00 none, 01 perfect, 10 good, 11 miss
- acc_lane  out  LANE_W  lane that produced the reported accuracy
- playing  out  1  high in PLAY state
- done  out  1  high in DONE state

Behaviour:
- Reset (rst=0 at a clk edge) applies regardless of state, including mid-song:
  - all shifters = 0, tick counter = 0, button history = all 1s
  - score, combo, max_combo, accuracy, acc_lane = 0
  - state = IDLE
- FSM:
  - IDLE: on start -> load all shifters from map_in, clear score/combo/max_combo/accuracy/tick counter, go to PLAY.
  - PLAY: on start -> IDLE (abort; shifters cleared, score/combo held). On tick when tick counter = MAP_LEN-1 -> DONE.
  - DONE: on start -> reload and PLAY, same as from IDLE. Otherwise hold all outputs.
- tick is ignored outside PLAY. Presses are ignored outside PLAY, but button history still updates.
- Press detection: press[l] = btn_q[l] & ~button[l], where btn_q is button registered every cycle.
  - A held button produces exactly one press.
- Window per lane: slot1 = perfect; slot0 (late) and slot2 (early) = good.
  - Priority on press: slot1, then slot0, then slot2. Only the single judged bit is cleared.
  - Perfect adds PERFECT_PTS; good adds GOOD_PTS; combo +1 per hit lane.
  - Press with no note in slots 0-2: no score change, combo unchanged; contributes "none".
- Tick in PLAY: every lane shifts right by 1 with 0 in at the MSB; tick counter +1.
  - Any lane whose bit0 is still set at that edge is a miss: combo = 0 and the miss is reported.
- Press and tick on the same cycle:
  - The press is judged first against pre-shift contents.
  - A bit cleared by that press is not counted as a miss.
  - The shift applies to the post-clear contents.
- Multiple lanes in one cycle:
  - Points are summed and combo increments by the number of hit lanes.
  - If any miss occurs that cycle, combo = 0 (miss overrides hits); hit points are still added.
  - Reported accuracy is the worst event: miss > good > perfect > none.
  - acc_lane = lowest-index lane with that event.
  - A cycle with no press and no miss leaves accuracy and acc_lane unchanged.
- Arithmetic:
  - score and combo saturate at all 1s; no wrap.
  - max_combo updates to the new combo whenever the new combo exceeds it, in the same cycle.
- Latency: all outputs are registered; effects of press/tick/start appear one clk after the triggering edge.
- lane_view is taken directly from the shifters, so it also has 1-cycle latency.

Test Plan:
- Reset mid-PLAY with score=5: rst=0 for one edge -> all outputs 0, playing=0, lane_view=0.
- LANES=1, map bit1=1; start, then press -> accuracy=01, score=2, combo=1; bit cleared in lane_view next cycle.
- Map bit0=1 in lane0, no press, one tick -> accuracy=11, acc_lane=0, combo=0, score unchanged.
- Lane0 slot1 and lane2 slot0 notes, both pressed in the same cycle with combo=3 -> score +3, combo=5, accuracy=10, acc_lane=2, max_combo=5.
- Press on lane1 (slot0 note) coinciding with tick -> judged good, no miss, combo +1.
- SCORE_W=8, score=254, perfect hit -> score=255; hold button low 10 cycles -> single judgment only.
- MAP_LEN ticks after start -> done=1, playing=0; further ticks and presses change nothing; start -> map reloaded, score=0, playing=1.
